// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter, LSB first, feeding a SIPO shift register
module piso_tx #(
  parameter int   WIDTH      = 4,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] words_sent
);

  // Bit counter only needs to reach WIDTH-1.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             sout_q;
  logic             sout_valid_q;
  logic             word_done_q;
  logic [CNT_W-1:0] words_sent_q;

  logic last_bit;
  logic accept;

  // The last payload bit is on the line; a new word may be taken without a gap.
  assign last_bit   = (state_q == S_SHIFT) && (cnt_q == LAST_IDX);
  assign load_ready = (state_q == S_IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = (state_q == S_SHIFT);
  assign word_done  = word_done_q;
  assign words_sent = words_sent_q;

  // Transmit FSM: load, shift out LSB first, strobe completion one cycle after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      word_done_q  <= 1'b0;
      words_sent_q <= '0;
    end else begin
      word_done_q <= 1'b0;
      // The downstream register has captured the final bit on this edge.
      if (last_bit) begin
        word_done_q  <= 1'b1;
        words_sent_q <= words_sent_q + CNT_W'(1);
      end
      if (accept) begin
        // Bit 0 goes straight to the line; the rest waits in the shift register.
        state_q      <= S_SHIFT;
        shreg_q      <= load_data;
        cnt_q        <= '0;
        sout_q       <= load_data[0];
        sout_valid_q <= 1'b1;
      end else if (state_q == S_SHIFT) begin
        if (last_bit) begin
          state_q      <= S_IDLE;
          shreg_q      <= '0;
          cnt_q        <= '0;
          sout_q       <= IDLE_LEVEL;
          sout_valid_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_q + CW'(1);
          shreg_q <= shreg_q >> 1;
          sout_q  <= shreg_q[1];
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - self-checking bench for piso_tx with a downstream SIPO model
module tb_piso_tx;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         load_ready, sout, sout_valid, busy, word_done;
  logic [7:0]   words_sent;
  logic         s2_ready, s2_sout, s2_valid, s2_busy, s2_done;
  logic [1:0]   s2_words;

  int vec  = 0;
  int errs = 0;

  piso_tx #(.WIDTH(W), .IDLE_LEVEL(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid), .busy(busy),
    .word_done(word_done), .words_sent(words_sent)
  );

  piso_tx #(.WIDTH(W), .IDLE_LEVEL(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(s2_ready), .sout(s2_sout), .sout_valid(s2_valid), .busy(s2_busy),
    .word_done(s2_done), .words_sent(s2_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit SIPO: new bit enters index 0, so after 4 shifts out[0:3] reads the word.
  logic [0:W-1] sipo;
  always @(posedge clk) sipo <= {sout, sipo[0:W-2]};

  // Reference timeline for the random test, indexed by cycle after each edge.
  logic         e_val  [0:1023];
  logic         e_bit  [0:1023];
  logic         e_done [0:1023];
  logic [W-1:0] e_word [0:1023];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    load_data  = '0;
    rst_n      = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      vec++; if (sout !== 1'b0)       begin errs++; $display("FAIL reset_sout c=%0d got %b exp 0", c, sout); end
      vec++; if (sout_valid !== 1'b0) begin errs++; $display("FAIL reset_sout_valid c=%0d got %b exp 0", c, sout_valid); end
      vec++; if (busy !== 1'b0)       begin errs++; $display("FAIL reset_busy c=%0d got %b exp 0", c, busy); end
      vec++; if (load_ready !== 1'b1) begin errs++; $display("FAIL reset_load_ready c=%0d got %b exp 1", c, load_ready); end
      vec++; if (word_done !== 1'b0)  begin errs++; $display("FAIL reset_word_done c=%0d got %b exp 0", c, word_done); end
      vec++; if (words_sent !== 8'd0) begin errs++; $display("FAIL reset_words_sent c=%0d got %0d exp 0", c, words_sent); end
      vec++; if (s2_words !== 2'd0)   begin errs++; $display("FAIL reset_words_sent2 c=%0d got %0d exp 0", c, s2_words); end
      tick();
    end
  endtask

  task automatic test_single_word();
    logic [W-1:0] w;
    w = 4'b1011;
    do_reset();
    load_data  = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    load_data  = '0;
    for (int i = 0; i < W; i++) begin
      vec++; if (sout !== w[i])       begin errs++; $display("FAIL single_sout bit=%0d got %b exp %b", i, sout, w[i]); end
      vec++; if (sout_valid !== 1'b1) begin errs++; $display("FAIL single_sout_valid bit=%0d got %b exp 1", i, sout_valid); end
      vec++; if (busy !== 1'b1)       begin errs++; $display("FAIL single_busy bit=%0d got %b exp 1", i, busy); end
      vec++; if (load_ready !== (i == W - 1)) begin errs++; $display("FAIL single_load_ready bit=%0d got %b exp %b", i, load_ready, (i == W - 1)); end
      vec++; if (word_done !== 1'b0)  begin errs++; $display("FAIL single_early_done bit=%0d got %b exp 0", i, word_done); end
      tick();
    end
    vec++; if (word_done !== 1'b1)  begin errs++; $display("FAIL single_word_done got %b exp 1", word_done); end
    vec++; if (sipo !== w)          begin errs++; $display("FAIL single_sipo got %h exp %h", sipo, w); end
    vec++; if (words_sent !== 8'd1) begin errs++; $display("FAIL single_words_sent got %0d exp 1", words_sent); end
    vec++; if (sout_valid !== 1'b0) begin errs++; $display("FAIL single_idle_valid got %b exp 0", sout_valid); end
    vec++; if (sout !== 1'b0)       begin errs++; $display("FAIL single_idle_sout got %b exp 0", sout); end
    tick();
    vec++; if (word_done !== 1'b0)  begin errs++; $display("FAIL single_done_pulse got %b exp 0", word_done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bits = 8'b0110_1011;
    do_reset();
    load_data  = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_data = 4'b0110;
    for (int j = 0; j < 8; j++) begin
      vec++; if (sout !== bits[j])    begin errs++; $display("FAIL b2b_sout cyc=%0d got %b exp %b", j + 1, sout, bits[j]); end
      vec++; if (sout_valid !== 1'b1) begin errs++; $display("FAIL b2b_sout_valid cyc=%0d got %b exp 1", j + 1, sout_valid); end
      vec++; if (word_done !== (j == 4)) begin errs++; $display("FAIL b2b_word_done cyc=%0d got %b exp %b", j + 1, word_done, (j == 4)); end
      if (j == 4) begin
        vec++; if (sipo !== 4'b1011)    begin errs++; $display("FAIL b2b_sipo1 got %h exp b", sipo); end
        vec++; if (words_sent !== 8'd1) begin errs++; $display("FAIL b2b_words1 got %0d exp 1", words_sent); end
      end
      tick();
      if (j == 3) load_valid = 1'b0;
    end
    vec++; if (word_done !== 1'b1)  begin errs++; $display("FAIL b2b_word_done2 got %b exp 1", word_done); end
    vec++; if (sipo !== 4'b0110)    begin errs++; $display("FAIL b2b_sipo2 got %h exp 6", sipo); end
    vec++; if (words_sent !== 8'd2) begin errs++; $display("FAIL b2b_words2 got %0d exp 2", words_sent); end
    vec++; if (sout_valid !== 1'b0) begin errs++; $display("FAIL b2b_idle got %b exp 0", sout_valid); end
  endtask

  task automatic test_data_hold();
    do_reset();
    load_data  = 4'hF;
    load_valid = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      vec++; if (sout !== (j < 4))    begin errs++; $display("FAIL hold_sout cyc=%0d got %b exp %b", j + 1, sout, (j < 4)); end
      vec++; if (sout_valid !== 1'b1) begin errs++; $display("FAIL hold_sout_valid cyc=%0d got %b exp 1", j + 1, sout_valid); end
      if (j == 1) load_data = 4'h0;
      tick();
      if (j == 3) load_valid = 1'b0;
    end
    vec++; if (sout_valid !== 1'b0) begin errs++; $display("FAIL hold_idle got %b exp 0", sout_valid); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    load_data  = 4'b1010;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    vec++; if (sout_valid !== 1'b1) begin errs++; $display("FAIL rstmid_pre_valid got %b exp 1", sout_valid); end
    vec++; if (busy !== 1'b1)       begin errs++; $display("FAIL rstmid_pre_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    vec++; if (sout !== 1'b0)       begin errs++; $display("FAIL rstmid_sout got %b exp 0", sout); end
    vec++; if (sout_valid !== 1'b0) begin errs++; $display("FAIL rstmid_sout_valid got %b exp 0", sout_valid); end
    vec++; if (busy !== 1'b0)       begin errs++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      vec++; if (word_done !== 1'b0)  begin errs++; $display("FAIL rstmid_word_done c=%0d got %b exp 0", c, word_done); end
      vec++; if (words_sent !== 8'd0) begin errs++; $display("FAIL rstmid_words c=%0d got %0d exp 0", c, words_sent); end
      tick();
    end
  endtask

  task automatic test_wrap();
    int exp2 [0:4];
    int n;
    exp2 = '{1, 2, 3, 0, 1};
    n = 0;
    do_reset();
    load_data  = 4'($urandom);
    load_valid = 1'b1;
    tick();
    for (int c = 1; c <= 22; c++) begin
      if (word_done === 1'b1 && n < 5) begin
        n++;
        vec++; if (words_sent !== 8'(n)) begin errs++; $display("FAIL wrap_words8 n=%0d got %0d exp %0d", n, words_sent, n); end
        vec++; if (int'(s2_words) !== exp2[n-1]) begin errs++; $display("FAIL wrap_words2 n=%0d got %0d exp %0d", n, s2_words, exp2[n-1]); end
      end
      load_data = 4'($urandom);
      tick();
      if (c == 16) load_valid = 1'b0;
    end
    vec++; if (n !== 5) begin errs++; $display("FAIL wrap_done_count got %0d exp 5", n); end
  endtask

  task automatic test_random();
    int exp_ws;
    logic v;
    logic [W-1:0] d;
    logic exp_sout;
    for (int i = 0; i < 1024; i++) begin
      e_val[i] = 1'b0; e_bit[i] = 1'b0; e_done[i] = 1'b0; e_word[i] = '0;
    end
    exp_ws = 0;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      if (e_done[t]) exp_ws++;
      exp_sout = e_val[t] ? e_bit[t] : 1'b0;
      vec++; if (sout !== exp_sout)        begin errs++; $display("FAIL rand_sout t=%0d got %b exp %b", t, sout, exp_sout); end
      vec++; if (sout_valid !== e_val[t])  begin errs++; $display("FAIL rand_sout_valid t=%0d got %b exp %b", t, sout_valid, e_val[t]); end
      vec++; if (busy !== e_val[t])        begin errs++; $display("FAIL rand_busy t=%0d got %b exp %b", t, busy, e_val[t]); end
      vec++; if (load_ready !== !e_val[t+1]) begin errs++; $display("FAIL rand_load_ready t=%0d got %b exp %b", t, load_ready, !e_val[t+1]); end
      vec++; if (word_done !== e_done[t])  begin errs++; $display("FAIL rand_word_done t=%0d got %b exp %b", t, word_done, e_done[t]); end
      vec++; if (words_sent !== 8'(exp_ws)) begin errs++; $display("FAIL rand_words t=%0d got %0d exp %0d", t, words_sent, exp_ws); end
      if (e_done[t]) begin
        vec++; if (sipo !== e_word[t]) begin errs++; $display("FAIL rand_sipo t=%0d got %h exp %h", t, sipo, e_word[t]); end
      end
      v = ($urandom_range(9) < 6) && (t < 590);
      d = 4'($urandom);
      load_valid = v;
      load_data  = d;
      if (v && !e_val[t+1]) begin
        for (int i = 0; i < W; i++) begin
          e_val[t+1+i] = 1'b1;
          e_bit[t+1+i] = d[i];
        end
        e_done[t+1+W] = 1'b1;
        e_word[t+1+W] = d;
      end
      tick();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_back_to_back();
    test_data_hold();
    test_reset_mid_word();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
